// File: rtl/uart_bus_pkg.sv
// rtl/uart_bus_pkg.sv - shared types and widths for the UART register bus sequencer
package uart_bus_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at a pointer, wrapping mod NREQ
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  int cand;

  // Scan from the farthest candidate back to ptr so the closest valid requester wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bus_sequencer.sv
// rtl/uart_bus_sequencer.sv - arbitrates requesters onto the UART register bus and sequences
// each access as setup -> strobe -> hold with registered pin outputs.
module uart_bus_sequencer
  import uart_bus_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        AddrBus,
  output logic                     n_ChipSelect,
  output logic                     n_rd,
  output logic                     n_we,
  output logic [DATA_W-1:0]        DataBusI,
  input  logic [DATA_W-1:0]        DataBusO,
  input  logic                     p_IrqSig,
  output logic                     irq_sync
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  bus_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               cap_we_q, cap_we_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]  cap_wdata_q, cap_wdata_d;

  logic [NREQ-1:0]    arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               grant_fire;

  logic               cs_n_d, rd_n_d, we_n_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  dbi_d, rdata_d;
  logic [NREQ-1:0]    rsp_valid_d;
  logic               irq_meta;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign grant_fire = (state_q == IDLE) && arb_any;
  assign req_ready  = grant_fire ? arb_grant : '0;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any)       state_d = SETUP;
      SETUP:   if (cnt_q == '0)   state_d = STROBE;
      STROBE:  if (cnt_q == '0)   state_d = HOLD;
      HOLD:    if (cnt_q == '0)   state_d = IDLE;
      default:                    state_d = IDLE;
    endcase

    // Each phase reloads its own length on entry and counts down to zero.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        SETUP:   cnt_d = SETUP_LD;
        STROBE:  cnt_d = STROBE_LD;
        HOLD:    cnt_d = HOLD_LD;
        default: cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    if (grant_fire) begin
      ptr_d       = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      owner_d     = arb_idx;
      cap_we_d    = req_we[arb_idx];
      cap_addr_d  = req_addr[ADDR_W*arb_idx +: ADDR_W];
      cap_wdata_d = req_wdata[DATA_W*arb_idx +: DATA_W];
    end
  end

  // Pin values are derived from the next state so the registered pins track the state exactly.
  always_comb begin
    cs_n_d  = (state_d == IDLE);
    addr_d  = (state_d != IDLE) ? cap_addr_d : '0;
    dbi_d   = ((state_d != IDLE) && cap_we_d) ? cap_wdata_d : '0;
    rd_n_d  = !((state_d == STROBE) && !cap_we_d);
    we_n_d  = !((state_d == STROBE) && cap_we_d);

    rsp_valid_d = '0;
    if ((state_q == HOLD) && (state_d == IDLE)) rsp_valid_d[owner_q] = 1'b1;

    rdata_d = rsp_rdata;
    if ((state_q == STROBE) && (cnt_q == '0) && !cap_we_q) rdata_d = DataBusO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_ChipSelect <= 1'b1;
      n_rd         <= 1'b1;
      n_we         <= 1'b1;
      AddrBus      <= '0;
      DataBusI     <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      irq_meta     <= 1'b0;
      irq_sync     <= 1'b0;
    end else begin
      n_ChipSelect <= cs_n_d;
      n_rd         <= rd_n_d;
      n_we         <= we_n_d;
      AddrBus      <= addr_d;
      DataBusI     <= dbi_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rdata_d;
      irq_meta     <= p_IrqSig;
      irq_sync     <= irq_meta;
    end
  end

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// tb/tb_uart_bus_sequencer.sv - directed self-checking bench for uart_bus_sequencer
module tb_uart_bus_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata, DataBusI, DataBusO;
  logic [3:0]  AddrBus;
  logic        busy, n_ChipSelect, n_rd, n_we, p_IrqSig, irq_sync;

  logic [1:0]  r2_valid, r2_ready, r2_we, r2_rsp_valid;
  logic [7:0]  r2_addr;
  logic [15:0] r2_wdata;
  logic [7:0]  r2_rdata, r2_dbi, r2_dbo;
  logic [3:0]  r2_abus;
  logic        r2_busy, r2_cs, r2_rd, r2_wen, r2_irq, r2_irq_sync;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rdata = 8'h00;

  uart_bus_sequencer u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .AddrBus(AddrBus), .n_ChipSelect(n_ChipSelect), .n_rd(n_rd), .n_we(n_we),
    .DataBusI(DataBusI), .DataBusO(DataBusO),
    .p_IrqSig(p_IrqSig), .irq_sync(irq_sync)
  );

  uart_bus_sequencer #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
    .req_addr(r2_addr), .req_wdata(r2_wdata),
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata), .busy(r2_busy),
    .AddrBus(r2_abus), .n_ChipSelect(r2_cs), .n_rd(r2_rd), .n_we(r2_wen),
    .DataBusI(r2_dbi), .DataBusO(r2_dbo),
    .p_IrqSig(r2_irq), .irq_sync(r2_irq_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full access on the default instance, checked cycle by cycle from grant (cycle 0) to response (cycle 5).
  task automatic do_access(input int idx, input bit we, input logic [3:0] a,
                           input logic [7:0] d, input logic [7:0] dbo, input string nm);
    logic [1:0] one;
    one = 2'b00;
    one[idx] = 1'b1;
    @(posedge clk); #1;
    req_valid = one;
    req_we[idx] = we;
    req_addr[idx*4 +: 4] = a;
    req_wdata[idx*8 +: 8] = d;
    DataBusO = dbo;
    if (!we) last_rdata = dbo;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d ready", nm, c), 32'(req_ready), (c == 0) ? 32'(one) : 0);
      check($sformatf("%s c%0d cs", nm, c), 32'(n_ChipSelect), (c >= 1 && c <= 4) ? 0 : 1);
      check($sformatf("%s c%0d n_we", nm, c), 32'(n_we), (we && c >= 2 && c <= 3) ? 0 : 1);
      check($sformatf("%s c%0d n_rd", nm, c), 32'(n_rd), (!we && c >= 2 && c <= 3) ? 0 : 1);
      check($sformatf("%s c%0d addr", nm, c), 32'(AddrBus), (c >= 1 && c <= 4) ? 32'(a) : 0);
      check($sformatf("%s c%0d dbi", nm, c), 32'(DataBusI), (we && c >= 1 && c <= 4) ? 32'(d) : 0);
      check($sformatf("%s c%0d rspv", nm, c), 32'(rsp_valid), (c == 5) ? 32'(one) : 0);
      check($sformatf("%s c%0d busy", nm, c), 32'(busy), (c >= 1 && c <= 4) ? 1 : 0);
      if (c == 5) check($sformatf("%s rdata", nm), 32'(rsp_rdata), 32'(last_rdata));
      if (c == 0) begin
        @(posedge clk); #1;
        req_valid = 2'b00;
      end
    end
  endtask

  initial begin
    int gcyc[4];
    logic [1:0] gval[4];
    int ng;
    int bad_rsp;

    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; DataBusO = '0; p_IrqSig = 1'b0;
    r2_valid = '0; r2_we = '0; r2_addr = '0; r2_wdata = '0; r2_dbo = '0; r2_irq = 1'b0;

    repeat (2) @(negedge clk);
    check("rst cs", 32'(n_ChipSelect), 1);
    check("rst n_rd", 32'(n_rd), 1);
    check("rst n_we", 32'(n_we), 1);
    check("rst addr", 32'(AddrBus), 0);
    check("rst dbi", 32'(DataBusI), 0);
    check("rst rdata", 32'(rsp_rdata), 0);
    check("rst rspv", 32'(rsp_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst irq", 32'(irq_sync), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_access(0, 1'b1, 4'h3, 8'hA5, 8'h00, "wr0");
    do_access(1, 1'b0, 4'h7, 8'h00, 8'h3C, "rd1");

    // Both requesters pending continuously: grants must alternate every 5 cycles.
    ng = 0;
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_we = 2'b11;
    for (int k = 0; k < 25 && ng < 4; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        gcyc[ng] = k;
        gval[ng] = req_ready;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("rot count", 32'(ng), 4);
    for (int i = 0; i < 4 && i < ng; i++) begin
      check($sformatf("rot g%0d val", i), 32'(gval[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rot g%0d cyc", i), 32'(gcyc[i]), 32'(5 * i));
    end
    repeat (6) @(posedge clk);

    do_access(0, 1'b1, 4'hE, 8'h42, 8'hFF, "wr0b");

    // Reset during the strobe of a write: pins release at once, no response, pointer back to 0.
    @(posedge clk); #1;
    req_valid = 2'b01; req_we = 2'b01; req_addr[3:0] = 4'h9; req_wdata[7:0] = 8'h5A;
    @(negedge clk);
    check("rst_mid ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid c2 n_we", 32'(n_we), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid n_we", 32'(n_we), 1);
    check("rst_mid cs", 32'(n_ChipSelect), 1);
    check("rst_mid busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) bad_rsp++;
    end
    check("rst_mid no rsp", 32'(bad_rsp), 0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_mid regrant", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (6) @(posedge clk);

    // Stretched timing instance: CS low cycles 1-6, strobe only cycle 4, response cycle 7.
    @(posedge clk); #1;
    r2_valid = 2'b01; r2_we = 2'b01; r2_addr[3:0] = 4'h1; r2_wdata[7:0] = 8'h11;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t2 c%0d ready", c), 32'(r2_ready), (c == 0) ? 1 : 0);
      check($sformatf("t2 c%0d cs", c), 32'(r2_cs), (c >= 1 && c <= 6) ? 0 : 1);
      check($sformatf("t2 c%0d n_we", c), 32'(r2_wen), (c == 4) ? 0 : 1);
      check($sformatf("t2 c%0d n_rd", c), 32'(r2_rd), 1);
      check($sformatf("t2 c%0d rspv", c), 32'(r2_rsp_valid), (c == 7) ? 1 : 0);
      if (c == 0) begin
        @(posedge clk); #1;
        r2_valid = 2'b00;
      end
    end

    // Interrupt synchroniser: two edges of latency on both transitions.
    @(posedge clk); #1;
    p_IrqSig = 1'b1;
    @(negedge clk);
    check("irq rise e0", 32'(irq_sync), 0);
    @(negedge clk);
    check("irq rise e1", 32'(irq_sync), 0);
    @(negedge clk);
    check("irq rise e2", 32'(irq_sync), 1);
    @(posedge clk); #1;
    p_IrqSig = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("irq fall e1", 32'(irq_sync), 1);
    @(negedge clk);
    check("irq fall e2", 32'(irq_sync), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
